// File: rtl/pipeline_exe_muldiv.sv
// rtl/pipeline_exe_muldiv.sv - EXE stage: single-cycle ALU, address adder, iterative radix-2 divider
// Registers results and pass-through fields into the EXE/MEM pipeline register.
module pipeline_exe_muldiv #(
  parameter logic [3:0] DMEM_NO = 4'h0,
  parameter int         XLEN    = 32
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            valid_d_i,
  input  logic [3:0]      alu_op_d_i,
  input  logic [XLEN-1:0] src_a_d_i,
  input  logic [XLEN-1:0] src_b_d_i,
  input  logic [XLEN-1:0] rs2_d_i,
  input  logic [3:0]      dmem_type_d_i,
  input  logic [XLEN-1:0] extended_imm_d_i,
  input  logic [XLEN-1:0] pc_plus_d_i,
  input  logic            reg_write_en_d_i,
  input  logic [4:0]      rd_idx_d_i,
  input  logic [3:0]      result_src_d_i,
  input  logic            flush_i,
  output logic            stall_o,
  output logic [XLEN-1:0] alu_result_e_o,
  output logic [XLEN-1:0] alu_calculation_e_o,
  output logic [XLEN-1:0] rs2_e_o,
  output logic [XLEN-1:0] extended_imm_e_o,
  output logic [XLEN-1:0] pc_plus_e_o,
  output logic [3:0]      dmem_type_e_o,
  output logic            reg_write_en_e_o,
  output logic [4:0]      rd_idx_e_o,
  output logic [3:0]      result_src_e_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } div_state_e;

  div_state_e state_q, state_d;

  logic [XLEN-1:0] alu_res;
  logic [4:0]      shamt;
  logic            is_div;
  logic            div_signed;
  logic            div_start;
  logic            div_done;
  logic            bubble;

  logic [XLEN-1:0] quo_q;
  logic [XLEN-1:0] rem_q;
  logic [XLEN-1:0] dvs_q;
  logic [4:0]      cnt_q;
  logic            neg_quo_q;
  logic            neg_rem_q;
  logic            is_rem_q;
  logic [XLEN:0]   trial;
  logic [XLEN-1:0] quo_fix;
  logic [XLEN-1:0] rem_fix;
  logic [XLEN-1:0] div_res;

  assign shamt      = src_b_d_i[4:0];
  assign is_div     = (alu_op_d_i >= 4'hA) && (alu_op_d_i <= 4'hD);
  assign div_signed = ~alu_op_d_i[0];

  always_comb begin
    alu_res = src_b_d_i;
    case (alu_op_d_i)
      4'h0: alu_res = src_a_d_i + src_b_d_i;
      4'h1: alu_res = src_a_d_i - src_b_d_i;
      4'h2: alu_res = src_a_d_i << shamt;
      4'h3: alu_res = {{(XLEN-1){1'b0}}, ($signed(src_a_d_i) < $signed(src_b_d_i))};
      4'h4: alu_res = {{(XLEN-1){1'b0}}, (src_a_d_i < src_b_d_i)};
      4'h5: alu_res = src_a_d_i ^ src_b_d_i;
      4'h6: alu_res = src_a_d_i >> shamt;
      4'h7: alu_res = $signed(src_a_d_i) >>> shamt;
      4'h8: alu_res = src_a_d_i | src_b_d_i;
      4'h9: alu_res = src_a_d_i & src_b_d_i;
      default: alu_res = src_b_d_i;
    endcase
  end

  // Flush overrides every state; the DONE cycle consumes the held divide without retriggering.
  always_comb begin
    state_d   = state_q;
    stall_o   = 1'b0;
    div_start = 1'b0;
    div_done  = 1'b0;
    if (flush_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (valid_d_i && is_div) begin
            stall_o   = 1'b1;
            div_start = 1'b1;
            state_d   = S_BUSY;
          end
        end
        S_BUSY: begin
          stall_o = 1'b1;
          if (cnt_q == '0) begin
            state_d = S_DONE;
          end
        end
        S_DONE: begin
          div_done = valid_d_i;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Restoring step: quo_q shifts the dividend out at the top and quotient bits in at the bottom.
  assign trial = {rem_q, quo_q[XLEN-1]} - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (div_start) begin
      quo_q     <= (div_signed && src_a_d_i[XLEN-1]) ? -src_a_d_i : src_a_d_i;
      dvs_q     <= (div_signed && src_b_d_i[XLEN-1]) ? -src_b_d_i : src_b_d_i;
      rem_q     <= '0;
      cnt_q     <= 5'd31;
      neg_quo_q <= div_signed && (src_a_d_i[XLEN-1] ^ src_b_d_i[XLEN-1]) && (src_b_d_i != '0);
      neg_rem_q <= div_signed && src_a_d_i[XLEN-1];
      is_rem_q  <= alu_op_d_i[2];
    end else if (state_q == S_BUSY) begin
      quo_q <= {quo_q[XLEN-2:0], ~trial[XLEN]};
      rem_q <= trial[XLEN] ? {rem_q[XLEN-2:0], quo_q[XLEN-1]} : trial[XLEN-1:0];
      cnt_q <= cnt_q - 5'd1;
    end
  end

  // b==0 naturally yields an all-ones quotient and remainder |a|, which the sign fix maps back to a.
  assign quo_fix = neg_quo_q ? -quo_q : quo_q;
  assign rem_fix = neg_rem_q ? -rem_q : rem_q;
  assign div_res = is_rem_q ? rem_fix : quo_fix;

  assign bubble = flush_i || !valid_d_i || stall_o;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      alu_result_e_o      <= '0;
      alu_calculation_e_o <= '0;
      rs2_e_o             <= '0;
      extended_imm_e_o    <= '0;
      pc_plus_e_o         <= '0;
      dmem_type_e_o       <= DMEM_NO;
      reg_write_en_e_o    <= 1'b0;
      rd_idx_e_o          <= '0;
      result_src_e_o      <= '0;
    end else begin
      alu_result_e_o      <= div_done ? div_res : alu_res;
      alu_calculation_e_o <= src_a_d_i + src_b_d_i;
      rs2_e_o             <= rs2_d_i;
      extended_imm_e_o    <= extended_imm_d_i;
      pc_plus_e_o         <= pc_plus_d_i;
      rd_idx_e_o          <= rd_idx_d_i;
      if (bubble) begin
        dmem_type_e_o    <= DMEM_NO;
        reg_write_en_e_o <= 1'b0;
        result_src_e_o   <= '0;
      end else begin
        dmem_type_e_o    <= dmem_type_d_i;
        reg_write_en_e_o <= reg_write_en_d_i;
        result_src_e_o   <= result_src_d_i;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_exe_muldiv.sv
// tb/tb_pipeline_exe_muldiv.sv - scoreboard bench for pipeline_exe_muldiv
// Driver pushes expected results; a negedge monitor pops and compares on every valid output.
module tb_pipeline_exe_muldiv;

  localparam logic [3:0] DMEM_NO = 4'h0;

  logic        clk = 1'b0;
  logic        resetn;
  logic        valid_d;
  logic [3:0]  alu_op_d;
  logic [31:0] src_a_d, src_b_d, rs2_d, imm_d, pc_plus_d;
  logic [3:0]  dmem_type_d, result_src_d;
  logic        we_d;
  logic [4:0]  rd_d;
  logic        flush;
  logic        stall;
  logic [31:0] alu_result_e, alu_calc_e, rs2_e, imm_e, pc_plus_e;
  logic [3:0]  dmem_type_e, result_src_e;
  logic        we_e;
  logic [4:0]  rd_e;

  always #5 clk = ~clk;

  pipeline_exe_muldiv #(.DMEM_NO(DMEM_NO), .XLEN(32)) dut (
    .clk                 (clk),
    .resetn              (resetn),
    .valid_d_i           (valid_d),
    .alu_op_d_i          (alu_op_d),
    .src_a_d_i           (src_a_d),
    .src_b_d_i           (src_b_d),
    .rs2_d_i             (rs2_d),
    .dmem_type_d_i       (dmem_type_d),
    .extended_imm_d_i    (imm_d),
    .pc_plus_d_i         (pc_plus_d),
    .reg_write_en_d_i    (we_d),
    .rd_idx_d_i          (rd_d),
    .result_src_d_i      (result_src_d),
    .flush_i             (flush),
    .stall_o             (stall),
    .alu_result_e_o      (alu_result_e),
    .alu_calculation_e_o (alu_calc_e),
    .rs2_e_o             (rs2_e),
    .extended_imm_e_o    (imm_e),
    .pc_plus_e_o         (pc_plus_e),
    .dmem_type_e_o       (dmem_type_e),
    .reg_write_en_e_o    (we_e),
    .rd_idx_e_o          (rd_e),
    .result_src_e_o      (result_src_e)
  );

  typedef struct {
    logic [31:0] res;
    logic [31:0] calc;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [3:0]  dmem;
    logic [3:0]  rsrc;
    logic [4:0]  rd;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;
  bit   mon_en   = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference model: plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] ref_model(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb, ua, ub, t;
    int sh;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'b0, a};
    ub = {32'b0, b};
    sh = int'(b[4:0]);
    t  = 0;
    case (op)
      4'h0: t = ua + ub;
      4'h1: t = ua - ub;
      4'h2: t = ua << sh;
      4'h3: t = (sa < sb) ? 1 : 0;
      4'h4: t = (ua < ub) ? 1 : 0;
      4'h5: t = ua ^ ub;
      4'h6: t = ua >> sh;
      4'h7: t = sa >>> sh;
      4'h8: t = ua | ub;
      4'h9: t = ua & ub;
      4'hA: t = (b == 0) ? -1 : sa / sb;
      4'hB: t = (b == 0) ? -1 : ua / ub;
      4'hC: t = (b == 0) ? sa : sa % sb;
      4'hD: t = (b == 0) ? ua : ua % ub;
      default: t = ub;
    endcase
    return t[31:0];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 6))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 40));
      4: return -32'($urandom_range(1, 40));
      default: return $urandom;
    endcase
  endfunction

  // Presents one instruction, waits for it to be accepted, and records its expected result.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    int   n;
    bit   is_div;
    valid_d      = 1'b1;
    alu_op_d     = op;
    src_a_d      = a;
    src_b_d      = b;
    rs2_d        = $urandom;
    imm_d        = $urandom;
    pc_plus_d    = $urandom;
    dmem_type_d  = 4'($urandom_range(1, 15));
    result_src_d = 4'b0001 << $urandom_range(0, 3);
    rd_d         = 5'($urandom);
    we_d         = 1'b1;
    is_div       = op inside {[4'hA:4'hD]};
    n = 0;
    while (1) begin
      @(negedge clk);
      if (stall === 1'b0) break;
      n++;
      if (n > 100) break;
    end
    chk("stall_cycles", 32'(n), is_div ? 32'd33 : 32'd0);
    if (n <= 100) begin
      e.res  = ref_model(op, a, b);
      e.calc = a + b;
      e.rs2  = rs2_d;
      e.imm  = imm_d;
      e.pc   = pc_plus_d;
      e.dmem = dmem_type_d;
      e.rsrc = result_src_d;
      e.rd   = rd_d;
      sb_q.push_back(e);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_alu_result", alu_result_e, 32'h0);
    chk("rst_alu_calc", alu_calc_e, 32'h0);
    chk("rst_rs2", rs2_e, 32'h0);
    chk("rst_imm", imm_e, 32'h0);
    chk("rst_pc_plus", pc_plus_e, 32'h0);
    chk("rst_dmem_type", {28'b0, dmem_type_e}, {28'b0, DMEM_NO});
    chk("rst_we", {31'b0, we_e}, 32'h0);
    chk("rst_rd", {27'b0, rd_e}, 32'h0);
    chk("rst_result_src", {28'b0, result_src_e}, 32'h0);
    chk("rst_stall", {31'b0, stall}, 32'h0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (we_e === 1'b1) begin
          if (sb_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_output actual=valid rd=%0d required=no_output", rd_e);
          end else begin
            e = sb_q.pop_front();
            chk("alu_result", alu_result_e, e.res);
            chk("alu_calculation", alu_calc_e, e.calc);
            chk("rs2", rs2_e, e.rs2);
            chk("extended_imm", imm_e, e.imm);
            chk("pc_plus", pc_plus_e, e.pc);
            chk("dmem_type", {28'b0, dmem_type_e}, {28'b0, e.dmem});
            chk("result_src", {28'b0, result_src_e}, {28'b0, e.rsrc});
            chk("rd_idx", {27'b0, rd_e}, {27'b0, e.rd});
          end
        end else begin
          chk("bubble_dmem_type", {28'b0, dmem_type_e}, {28'b0, DMEM_NO});
          chk("bubble_result_src", {28'b0, result_src_e}, 32'h0);
        end
      end
    end
  end

  logic [3:0]  dir_op [10] = '{4'h0, 4'hB, 4'hD, 4'hA, 4'hC, 4'hA, 4'hC, 4'hB, 4'hD, 4'hA};
  logic [31:0] dir_a  [10] = '{32'd5, 32'd100, 32'd100, -32'd7, -32'd7, 32'h8000_0000,
                               32'h8000_0000, 32'd9, 32'd9, -32'd9};
  logic [31:0] dir_b  [10] = '{32'd7, 32'd7, 32'd7, 32'd2, 32'd2, 32'hFFFF_FFFF,
                               32'hFFFF_FFFF, 32'd0, 32'd0, 32'd0};

  initial begin : driver
    resetn       = 1'b0;
    valid_d      = 1'b0;
    flush        = 1'b0;
    alu_op_d     = 4'h0;
    src_a_d      = 32'h1234_5678;
    src_b_d      = 32'h0BAD_F00D;
    rs2_d        = 32'hDEAD_BEEF;
    imm_d        = 32'hCAFE_0001;
    pc_plus_d    = 32'h0000_1004;
    dmem_type_d  = 4'h5;
    result_src_d = 4'b0010;
    rd_d         = 5'd17;
    we_d         = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    resetn = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 10; i++) begin
      issue(dir_op[i], dir_a[i], dir_b[i]);
    end

    for (int i = 0; i < 60; i++) begin
      issue(4'($urandom_range(0, 15)), pick_operand(), pick_operand());
    end

    // Flush on the tenth stalled cycle of a DIV.
    valid_d  = 1'b1;
    alu_op_d = 4'hA;
    src_a_d  = -32'd100;
    src_b_d  = 32'd3;
    we_d     = 1'b1;
    repeat (9) @(negedge clk);
    @(posedge clk);
    #1;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_stall", {31'b0, stall}, 32'h0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    issue(4'h0, 32'd11, 32'd22);

    // One-cycle reset in the middle of a DIVU.
    valid_d  = 1'b1;
    alu_op_d = 4'hB;
    src_a_d  = 32'd1000;
    src_b_d  = 32'd13;
    repeat (15) @(negedge clk);
    @(posedge clk);
    #1;
    resetn  = 1'b0;
    valid_d = 1'b0;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    issue(4'hB, 32'd1000, 32'd13);
    issue(4'hD, 32'd1000, 32'd13);

    valid_d = 1'b0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
